fetch_unit: RTL and testbench

//  Instruction-fetch stage between the PC register and decode. Drives the PC's write/next value,

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: data width, the NOP encoding,
// the fetch FSM state encoding and the sequential PC step.
package riscv_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // IDLE: may issue a request. WAIT: one request outstanding.
  // DROP: outstanding response was squashed by a redirect and will be discarded.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Instructions are word aligned, so the low two address bits are cleared.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer advance with explicit wrap at DEPTH.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write: data only, so no reset is needed.
  // NOTE: the storage array is deliberately left unreset; count_q gates its
  // visibility, and leaving it out of reset keeps it a plain RAM-style array.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register, issues one imem request
// at a time, buffers returned words with their PC, and squashes in-flight
// responses on a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] req_pc_q;
  logic [CW-1:0]   count;
  logic [63:0]     head;
  logic            req_hs, push, pop;

  // Request, PC update and FIFO control decisions for this cycle.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    imem_req_valid = 1'b0;
    if (res_n && state_q == FETCH_IDLE && !redirect && count < CW'(DEPTH))
      imem_req_valid = 1'b1;
    req_hs   = imem_req_valid && imem_req_ready;
    pc_write = res_n && (redirect || req_hs);
    pc_next  = redirect ? align_pc(redirect_pc) : pc + PC_STEP;
    push     = (state_q == FETCH_WAIT) && imem_resp_valid && !redirect;
    pop      = if_valid && if_ready;
  end

  // Fetch FSM and the PC of the outstanding request.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= FETCH_IDLE;
      req_pc_q <= '0;
    end else begin
      case (state_q)
        FETCH_IDLE: if (req_hs) begin
          state_q  <= FETCH_WAIT;
          req_pc_q <= pc;
        end
        FETCH_WAIT: begin
          if (imem_resp_valid) state_q <= FETCH_IDLE;
          else if (redirect)   state_q <= FETCH_DROP;
        end
        FETCH_DROP: if (imem_resp_valid) state_q <= FETCH_IDLE;
        default:    state_q <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .push_data ({req_pc_q, imem_resp_data}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? head[63:32] : '0;
  assign if_instr  = if_valid ? head[31:0]  : INSTR_NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the fetch
// buffer plus a latency-randomised instruction memory and the PC register.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .res_n           (res_n),
    .pc              (pc),
    .pc_write        (pc_write),
    .pc_next         (pc_next),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: buffered {pc, instr} words, one outstanding request, squash flag.
  logic [63:0] q[$];
  bit          outstanding, squashed;
  logic [31:0] m_req_pc;
  // Memory: response countdown for the one accepted request.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          force_delay;
  bit          force_data_en;
  logic [31:0] force_data;
  // Expected outputs for the current cycle.
  bit          e_req, e_pcw, e_ifv;
  logic [31:0] e_pcn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    outstanding     = 0;
    squashed        = 0;
    mem_busy        = 0;
    mem_cnt         = 0;
    pc              = 32'h0;
    imem_resp_valid = 1'b0;
  endtask

  // First half of a cycle: drive memory response, predict, compare at negedge.
  task automatic cycle_begin();
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? mem_data : $urandom;
    e_req = res_n && !outstanding && !redirect && (q.size() < DEPTH);
    e_pcw = res_n && (redirect || (e_req && imem_req_ready));
    e_pcn = redirect ? {redirect_pc[31:2], 2'b00} : pc + 32'd4;
    e_ifv = res_n && (q.size() != 0);
    @(negedge clk);
    check("imem_req_valid", imem_req_valid, e_req);
    if (e_req) check("imem_addr", imem_addr, pc);
    check("pc_write", pc_write, e_pcw);
    if (e_pcw) check("pc_next", pc_next, e_pcn);
    check("if_valid", if_valid, e_ifv);
    if (e_ifv) begin
      check("if_pc", if_pc, q[0][63:32]);
      check("if_instr", if_instr, q[0][31:0]);
    end
  endtask

  // Second half: after the edge, advance model, memory and PC register.
  task automatic cycle_end();
    bit resp, acc;
    @(posedge clk);
    #1;
    if (!res_n) begin
      model_reset();
    end else begin
      resp = imem_resp_valid;
      acc  = e_req && imem_req_ready;
      if (redirect) q.delete();
      else if (e_ifv && if_ready) void'(q.pop_front());
      if (outstanding && resp) begin
        if (!squashed && !redirect) q.push_back({m_req_pc, imem_resp_data});
        outstanding = 0;
        squashed    = 0;
      end else if (outstanding && redirect) begin
        squashed = 1;
      end else if (acc) begin
        outstanding = 1;
        m_req_pc    = pc;
      end
      if (resp) mem_busy = 0;
      if (acc) begin
        mem_busy = 1;
        mem_cnt  = (force_delay != 0) ? force_delay - 1 : int'($urandom_range(0, 2));
        mem_data = force_data_en ? force_data : $urandom;
      end else if (mem_busy && mem_cnt > 0) begin
        mem_cnt--;
      end
      if (e_pcw) pc = e_pcn;
    end
  endtask

  task automatic tick();
    cycle_begin();
    cycle_end();
  endtask

  initial begin
    res_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    if_ready = 1'b0; imem_resp_data = '0; force_delay = 0; force_data_en = 0;
    force_data = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state.
    cycle_begin();
    check("rst req_valid", imem_req_valid, 0);
    check("rst if_valid", if_valid, 0);
    check("rst pc_write", pc_write, 0);
    cycle_end();

    // First fetch at pc 0, response one cycle later.
    res_n = 1'b1; imem_req_ready = 1'b1; force_delay = 1;
    force_data_en = 1; force_data = 32'h0050_0093;
    cycle_begin();
    check("t1 imem_addr", imem_addr, 32'h0);
    check("t1 pc_write", pc_write, 1);
    check("t1 pc_next", pc_next, 32'h4);
    cycle_end();
    force_data_en = 0;
    cycle_begin();
    check("t2 wait req_valid", imem_req_valid, 0);
    cycle_end();
    cycle_begin();
    check("t2 if_valid", if_valid, 1);
    check("t2 if_pc", if_pc, 32'h0);
    check("t2 if_instr", if_instr, 32'h0050_0093);
    check("t2 next addr", imem_addr, 32'h4);
    cycle_end();
    tick();
    // Backpressure: two words held, no further request.
    cycle_begin();
    check("t3 full req_valid", imem_req_valid, 0);
    check("t3 full pc_write", pc_write, 0);
    cycle_end();
    if_ready = 1'b1;
    cycle_begin();
    check("t3 pop0 if_pc", if_pc, 32'h0);
    cycle_end();
    cycle_begin();
    check("t3 pop1 if_pc", if_pc, 32'h4);
    cycle_end();

    // Asynchronous reset while a request is outstanding.
    res_n = 1'b0;
    #1;
    check("t1 async req_valid", imem_req_valid, 0);
    check("t1 async if_valid", if_valid, 0);
    model_reset();
    tick();

    // Redirect in WAIT: response arrives late and is dropped.
    res_n = 1'b1; force_delay = 3;
    cycle_begin();
    check("t4 addr0", imem_addr, 32'h0);
    check("t4 pc_next0", pc_next, 32'h4);
    cycle_end();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle_begin();
    check("t4 redir pc_next", pc_next, 32'h100);
    check("t4 redir req_valid", imem_req_valid, 0);
    cycle_end();
    redirect = 1'b0;
    cycle_begin();
    check("t4 drop req_valid", imem_req_valid, 0);
    cycle_end();
    cycle_begin();
    check("t4 drop resp req_valid", imem_req_valid, 0);
    cycle_end();
    force_delay = 1; if_ready = 1'b0;
    cycle_begin();
    check("t4 if_valid stays 0", if_valid, 0);
    check("t4 refetch addr", imem_addr, 32'h100);
    cycle_end();
    tick();
    tick();

    // Redirect with response, pop and buffered word all in the same cycle.
    redirect = 1'b1; redirect_pc = 32'h103; if_ready = 1'b1;
    cycle_begin();
    check("t5 resp valid", imem_resp_valid, 1);
    check("t6 pc_next aligned", pc_next, 32'h100);
    cycle_end();
    redirect = 1'b0; imem_req_ready = 1'b0;
    cycle_begin();
    check("t5 flushed if_valid", if_valid, 0);
    check("t5 addr", imem_addr, 32'h100);
    cycle_end();

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cycle_begin();
    check("t6 pc_next top", pc_next, 32'hFFFF_FFFC);
    cycle_end();
    redirect = 1'b0; imem_req_ready = 1'b1;
    cycle_begin();
    check("t6 wrap addr", imem_addr, 32'hFFFF_FFFC);
    check("t6 wrap pc_next", pc_next, 32'h0);
    cycle_end();
    force_delay = 0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect       = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
